// File: rtl/timer_alarm_pkg.sv
// rtl/timer_alarm_pkg.sv - shared types and helpers for the alarm scheduler
package timer_alarm_pkg;

  // Scheduler sequencing: storage clear after reset, then continuous scanning.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Per-channel mode bits; cmp and period live in separately sized arrays
  // because their width follows the DATA_W parameter of the instance.
  typedef struct packed {
    logic periodic;
    logic armed;
  } ch_mode_t;

  // Full time/compare/period width derived from the half-width parameter.
  function automatic int time_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/timer_alarm_cmp.sv
// rtl/timer_alarm_cmp.sv - wrap-safe due test and periodic reload adder
module timer_alarm_cmp #(
  parameter int TW = 64
) (
  input  logic [TW-1:0] time_val,
  input  logic [TW-1:0] cmp_val,
  input  logic [TW-1:0] period_val,
  output logic          due,
  output logic          period_zero,
  output logic [TW-1:0] next_cmp
);

  logic [TW-1:0] diff;

  // Due when time is at or past cmp within half the counter range.
  always_comb begin
    diff        = time_val - cmp_val;
    due         = ~diff[TW-1];
    period_zero = (period_val == '0);
    next_cmp    = cmp_val + period_val;
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// rtl/timer_alarm_sched.sv - multi-channel alarm scheduler with round-robin scan
module timer_alarm_sched
  import timer_alarm_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_CH   = 4,
  localparam int CH_W   = $clog2(N_CH),
  localparam int TW     = time_w(DATA_W)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            cke_i,
  input  logic [TW-1:0]   time_i,
  input  logic            enable_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [CH_W-1:0] cfg_ch_i,
  input  logic            cfg_arm_i,
  input  logic            cfg_periodic_i,
  input  logic [TW-1:0]   cfg_cmp_i,
  input  logic [TW-1:0]   cfg_period_i,
  input  logic [N_CH-1:0] irq_en_i,
  input  logic [N_CH-1:0] ack_i,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] overrun_o,
  output logic [N_CH-1:0] armed_o,
  output logic            irq_o
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t          state_q, state_d;
  logic [CH_W-1:0] init_cnt_q;
  logic [CH_W-1:0] idx_q;
  logic [TW-1:0]   cmp_q    [N_CH];
  logic [TW-1:0]   period_q [N_CH];
  ch_mode_t        mode_q   [N_CH];
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] overrun_q;
  logic            irq_q;

  logic            cfg_ready;
  logic            visit;
  logic            cfg_acc;
  logic            hit_cfg;
  logic            due;
  logic            period_zero;
  logic            fire;
  logic            reload;
  logic [TW-1:0]   next_cmp;

  // Single comparator shared by all channels through the scan index.
  timer_alarm_cmp #(.TW(TW)) u_cmp (
    .time_val    (time_i),
    .cmp_val     (cmp_q[idx_q]),
    .period_val  (period_q[idx_q]),
    .due         (due),
    .period_zero (period_zero),
    .next_cmp    (next_cmp)
  );

  // Next state plus the state-dependent handshake and scan strobes.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    visit     = 1'b0;
    case (state_q)
      ST_INIT: if (cke_i && init_cnt_q == LAST_CH) state_d = ST_SCAN;
      ST_SCAN: begin
        cfg_ready = cke_i;
        visit     = cke_i & enable_i;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Fire decision for the visited channel; a config to it discards the visit.
  always_comb begin
    cfg_acc = cfg_valid_i & cfg_ready;
    hit_cfg = cfg_acc && (cfg_ch_i == idx_q);
    fire    = visit && mode_q[idx_q].armed && due && !hit_cfg;
    reload  = mode_q[idx_q].periodic && !period_zero;
  end

  // State register, init counter and round-robin scan index.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      idx_q      <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (state_q == ST_INIT)
        init_cnt_q <= (init_cnt_q == LAST_CH) ? '0 : init_cnt_q + CH_W'(1);
      if (visit)
        idx_q <= (idx_q == LAST_CH) ? '0 : idx_q + CH_W'(1);
    end
  end

  // Channel storage: init clear, then config, then fire reload/disarm.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N_CH; k++) mode_q[k] <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < N_CH; k++) begin
        if (state_q == ST_INIT) begin
          if (init_cnt_q == CH_W'(k)) begin
            cmp_q[k]    <= '0;
            period_q[k] <= '0;
            mode_q[k]   <= '0;
          end
        end else if (cfg_acc && cfg_ch_i == CH_W'(k)) begin
          if (cfg_arm_i) begin
            cmp_q[k]    <= cfg_cmp_i;
            period_q[k] <= cfg_period_i;
            mode_q[k]   <= '{periodic: cfg_periodic_i, armed: 1'b1};
          end else begin
            mode_q[k].armed <= 1'b0;
          end
        end else if (fire && idx_q == CH_W'(k)) begin
          if (reload) cmp_q[k] <= next_cmp;
          else        mode_q[k].armed <= 1'b0;
        end
      end
    end
  end

  // Pending/overrun flags (fire beats ack) and the registered interrupt.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      overrun_q <= '0;
      irq_q     <= 1'b0;
    end else if (cke_i) begin
      for (int k = 0; k < N_CH; k++) begin
        if (fire && idx_q == CH_W'(k)) begin
          pending_q[k] <= 1'b1;
          if (pending_q[k]) overrun_q[k] <= 1'b1;
        end else if (ack_i[k]) begin
          pending_q[k] <= 1'b0;
          overrun_q[k] <= 1'b0;
        end
      end
      irq_q <= |(pending_q & irq_en_i);
    end
  end

  // Armed status gathered from the per-channel mode bits.
  always_comb begin
    armed_o = '0;
    for (int k = 0; k < N_CH; k++) armed_o[k] = mode_q[k].armed;
  end

  assign cfg_ready_o = cfg_ready;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// tb/tb_timer_alarm_sched.sv - self-checking bench for timer_alarm_sched
module tb_timer_alarm_sched;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cke = 1'b1;
  logic [63:0]     time_v = '0;
  logic            enable = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready_o;
  logic [CH_W-1:0] cfg_ch = '0;
  logic            cfg_arm = 1'b0;
  logic            cfg_periodic = 1'b0;
  logic [63:0]     cfg_cmp = '0;
  logic [63:0]     cfg_period = '0;
  logic [N_CH-1:0] irq_en = '0;
  logic [N_CH-1:0] ack = '0;
  logic [N_CH-1:0] pending_o, overrun_o, armed_o;
  logic            irq_o;

  timer_alarm_sched #(.DATA_W(32), .N_CH(N_CH)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cke_i          (cke),
    .time_i         (time_v),
    .enable_i       (enable),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_ch_i       (cfg_ch),
    .cfg_arm_i      (cfg_arm),
    .cfg_periodic_i (cfg_periodic),
    .cfg_cmp_i      (cfg_cmp),
    .cfg_period_i   (cfg_period),
    .irq_en_i       (irq_en),
    .ack_i          (ack),
    .pending_o      (pending_o),
    .overrun_o      (overrun_o),
    .armed_o        (armed_o),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model
  logic [63:0]     m_cmp [N_CH];
  logic [63:0]     m_per [N_CH];
  logic [N_CH-1:0] m_periodic, m_armed, m_pend, m_ovr, old_pend;
  logic            m_irq;
  int              m_init_left;
  int              m_idx;
  int              fch;
  bit              acc;
  bit              m_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init_left = N_CH;
      m_idx = 0;
      m_pend = '0;
      m_ovr = '0;
      m_armed = '0;
      m_periodic = '0;
      m_irq = 1'b0;
      m_valid = 1;
    end else if (cke) begin
      old_pend = m_pend;
      fch = -1;
      acc = (m_init_left == 0) && cfg_valid;
      m_irq = |(old_pend & irq_en);
      if (m_init_left > 0) begin
        m_cmp[N_CH - m_init_left] = '0;
        m_per[N_CH - m_init_left] = '0;
        m_periodic[N_CH - m_init_left] = 1'b0;
        m_armed[N_CH - m_init_left] = 1'b0;
        m_init_left--;
      end else begin
        if (enable) begin
          if (m_armed[m_idx] && !(acc && int'(cfg_ch) == m_idx) &&
              $signed(time_v - m_cmp[m_idx]) >= 0)
            fch = m_idx;
          if (fch >= 0) begin
            if (m_periodic[fch] && m_per[fch] != 0) m_cmp[fch] = m_cmp[fch] + m_per[fch];
            else m_armed[fch] = 1'b0;
          end
          m_idx = (m_idx + 1) % N_CH;
        end
        if (acc) begin
          if (cfg_arm) begin
            m_cmp[cfg_ch] = cfg_cmp;
            m_per[cfg_ch] = cfg_period;
            m_periodic[cfg_ch] = cfg_periodic;
            m_armed[cfg_ch] = 1'b1;
          end else begin
            m_armed[cfg_ch] = 1'b0;
          end
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        if (k == fch) begin
          if (old_pend[k]) m_ovr[k] = 1'b1;
          m_pend[k] = 1'b1;
        end else if (ack[k]) begin
          m_pend[k] = 1'b0;
          m_ovr[k] = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cfg_ready", cfg_ready_o, (m_init_left == 0) && cke);
      chk("pending", pending_o, m_pend);
      chk("overrun", overrun_o, m_ovr);
      chk("armed", armed_o, m_armed);
      chk("irq", irq_o, m_irq);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic count_init(output int zeros);
    zeros = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cfg_ready_o === 1'b1) break;
      zeros++;
    end
    step();
  endtask

  task automatic do_cfg(input int ch, input bit arm, input bit per,
                        input logic [63:0] c, input logic [63:0] p);
    cfg_ch = CH_W'(ch);
    cfg_arm = arm;
    cfg_periodic = per;
    cfg_cmp = c;
    cfg_period = p;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pend(input int ch, input int max_cyc, output bit seen);
    seen = 0;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      if (pending_o[ch] === 1'b1) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic go_to_idx(input int target);
    for (int n = 0; n < 8; n++) begin
      if (m_idx == target) break;
      step();
    end
  endtask

  task automatic pulse_ack(input logic [N_CH-1:0] a);
    ack = a;
    step();
    ack = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int  zeros;
  bit  seen;
  logic [63:0] tv;

  initial begin
    // Reset and init length
    step();
    step();
    chk("rst_pending", pending_o, 4'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_ready", cfg_ready_o, 1'b0);
    rst_n = 1'b1;
    count_init(zeros);
    chk("init_len", zeros, 4);

    // One-shot on ch2
    irq_en = 4'b0100;
    time_v = 64'd90;
    do_cfg(2, 1, 0, 64'd100, 64'd0);
    for (int t = 90; t < 100; t++) begin
      time_v = 64'(t);
      step();
    end
    chk("oneshot_early", pending_o[2], 1'b0);
    time_v = 64'd100;
    wait_pend(2, 4, seen);
    chk("oneshot_fire", seen, 1'b1);
    chk("oneshot_model", m_pend[2], 1'b1);
    chk("oneshot_disarm", armed_o[2], 1'b0);
    step();
    chk("oneshot_irq", irq_o, 1'b1);
    pulse_ack(4'b0100);
    chk("oneshot_ack", pending_o[2], 1'b0);

    // Periodic on ch0, irq masked
    irq_en = 4'b0000;
    time_v = 64'd40;
    do_cfg(0, 1, 1, 64'd50, 64'd20);
    for (int t = 40; t <= 95; t++) begin
      time_v = 64'(t);
      step();
    end
    chk("per_pending", pending_o[0], 1'b1);
    chk("per_overrun", overrun_o[0], 1'b1);
    chk("per_armed", armed_o[0], 1'b1);
    chk("per_model_cmp", m_cmp[0], 64'd110);
    chk("per_irq_masked", irq_o, 1'b0);
    pulse_ack(4'b0001);
    chk("per_ack_pend", pending_o[0], 1'b0);
    chk("per_ack_ovr", overrun_o[0], 1'b0);
    do_cfg(0, 0, 0, 64'd0, 64'd0);

    // Wrap-safe compare on ch1
    time_v = 64'hFFFF_FFFF_FFFF_FFF0;
    do_cfg(1, 1, 0, 64'd5, 64'd0);
    repeat (8) step();
    chk("wrap_before", pending_o[1], 1'b0);
    time_v = 64'd3;
    repeat (8) step();
    chk("wrap_short", pending_o[1], 1'b0);
    time_v = 64'd6;
    wait_pend(1, 4, seen);
    chk("wrap_fire", seen, 1'b1);
    pulse_ack(4'b0010);

    // Config collides with the visit of ch3
    time_v = 64'd0;
    do_cfg(3, 1, 0, 64'd1000, 64'd0);
    go_to_idx(3);
    time_v = 64'd2000;
    do_cfg(3, 1, 0, 64'd5000, 64'd0);
    chk("coll_cfg_pend", pending_o[3], 1'b0);
    chk("coll_cfg_armed", armed_o[3], 1'b1);
    repeat (8) step();
    chk("coll_cfg_newcmp", pending_o[3], 1'b0);
    time_v = 64'd5000;
    wait_pend(3, 4, seen);
    chk("coll_cfg_fire", seen, 1'b1);
    pulse_ack(4'b1000);

    // Ack collides with a fire on ch1
    time_v = 64'd20;
    do_cfg(1, 1, 1, 64'd10, 64'd1000);
    wait_pend(1, 4, seen);
    chk("coll_ack_first", seen, 1'b1);
    time_v = 64'd0;
    go_to_idx(1);
    time_v = 64'd1500;
    pulse_ack(4'b0010);
    chk("coll_ack_pend", pending_o[1], 1'b1);
    chk("coll_ack_ovr", overrun_o[1], 1'b1);
    do_cfg(1, 0, 0, 64'd0, 64'd0);
    pulse_ack(4'b0010);
    chk("coll_ack_clear", pending_o[1], 1'b0);

    // Scanner paused by enable
    enable = 1'b0;
    time_v = 64'd400;
    do_cfg(0, 1, 0, 64'd300, 64'd0);
    repeat (10) step();
    chk("pause_nofire", pending_o[0], 1'b0);
    enable = 1'b1;
    wait_pend(0, 4, seen);
    chk("pause_resume", seen, 1'b1);

    // Reset in the middle of scanning
    irq_en = 4'b1111;
    step();
    step();
    chk("prereset_irq", irq_o, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midrst_pending", pending_o, 4'b0);
    chk("midrst_irq", irq_o, 1'b0);
    chk("midrst_ready", cfg_ready_o, 1'b0);
    rst_n = 1'b1;
    count_init(zeros);
    chk("midrst_init_len", zeros, 4);

    // Randomized traffic against the model
    tv = 64'd1000;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cke = ($urandom_range(0, 9) != 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) tv = 64'hFFFF_FFFF_FFFF_FFC0;
      else tv = tv + 64'($urandom_range(0, 4));
      time_v = tv;
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch = CH_W'($urandom_range(0, N_CH - 1));
      cfg_arm = ($urandom_range(0, 9) < 7);
      cfg_periodic = $urandom_range(0, 1);
      cfg_cmp = tv + 64'($urandom_range(0, 60)) - 64'd20;
      cfg_period = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 30));
      ack = ($urandom_range(0, 9) == 0) ? N_CH'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 19) == 0) irq_en = N_CH'($urandom_range(0, 15));
      step();
    end
    rst_n = 1'b1;
    cke = 1'b1;
    cfg_valid = 1'b0;
    ack = '0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_alarm_sched.md
Name: timer_alarm_sched

Overview:
- Multi-channel alarm scheduler layered on the free-running 64-bit timer counter.
- Holds N_CH compare channels, each one-shot or periodic, and time-shares a single wrap-safe 64-bit comparator across them with a round-robin scanner.
- Raises per-channel pending flags and one combined interrupt for the CPU-side register block.
- Sits between the timer core's counter output and the software register interface.

Parameters:
- DATA_W, 32, half-width of time value; time, compare and period are 2*DATA_W bits.
- N_CH, 4, number of alarm channels (2..16).
- CH_W, $clog2(N_CH), channel index width (derived, not overridable).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous active-low reset.
- cke_i  in  1  clock enable; all state holds when low.
- time_i  in  2*DATA_W  current counter value from timer core.
- enable_i  in  1  global scan enable; scanner pauses when low, config still accepted.
- cfg_valid_i  in  1  channel config request.
- cfg_ready_o  out  1  config accepted when valid&ready.
- cfg_ch_i  in  CH_W  target channel.
- cfg_arm_i  in  1  1 = arm, 0 = disarm.
- cfg_periodic_i  in  1  periodic mode.
- cfg_cmp_i  in  2*DATA_W  absolute compare time.
- cfg_period_i  in  2*DATA_W  reload period.
- irq_en_i  in  N_CH  per-channel interrupt mask.
- ack_i  in  N_CH  pulse; clears pending bits.
- pending_o  out  N_CH  per-channel fired flags.
- overrun_o  out  N_CH  sticky: fired while already pending (cleared by ack).
- armed_o  out  N_CH  channel armed status.
- irq_o  out  1  registered |(pending & irq_en).

Behaviour:
- Reset (rst_n_i low at clk edge):
  - FSM -> INIT; scan index 0.
  - pending_o, overrun_o, armed_o, irq_o = 0; cfg_ready_o = 0.
- FSM states:
  - INIT: clears channel storage (cmp, period, mode) one channel per cycle for N_CH cycles with cfg_ready_o = 0, then goes to SCAN.
  - SCAN: cfg_ready_o = 1.
  - Reset asserted mid-SCAN or mid-INIT restarts INIT.
- Config: accepted in one cycle and written at the clock edge.
  - Arm loads cmp/period/mode and sets armed; disarm clears armed only.
  - Config never touches pending or overrun.
- Scanner: in SCAN with enable_i & cke_i, visits channel idx each cycle, then idx = (idx == N_CH-1) ? 0 : idx+1.
  - Paused (enable_i low): idx holds.
  - Worst-case detection latency: N_CH cycles after time_i reaches cmp.
- Fire condition (armed channel only): MSB of (time_i - cmp), computed modulo 2^(2*DATA_W), is 0. Wrap-safe; "at or past" compare time.
- On fire (one fire per visit):
  - pending[idx] <= 1; if pending[idx] was already 1, overrun[idx] <= 1.
  - Periodic with period != 0: cmp <= cmp + period (modulo), stays armed. Catch-up happens one fire per subsequent visit.
  - One-shot, or periodic with period == 0: armed <= 0.
- Collisions:
  - Config to the channel being visited in the same cycle: config wins; the visit's fire and reload are discarded.
  - ack_i[k] and fire on k in the same cycle: fire wins; pending[k] stays 1, overrun unchanged by the ack.
  - ack_i[k] otherwise clears pending[k] and overrun[k] next cycle.
- irq_o is registered: one cycle after a pending or irq_en change.

Decomposition:
- Shared package timer_alarm_pkg:
  - FSM state encoding (INIT, SCAN).
  - Channel record fields: cmp, period, periodic, armed.
  - Helper constant for the 2*DATA_W width.
- Channel storage uses iob_reg_e-style registers.
- One natural sub-module, timer_alarm_cmp: combinational wrap-safe compare plus reload adder, instantiated once and shared by the scanner.

Test Plan:
- Reset then release: cfg_ready_o = 0 for exactly N_CH=4 cycles, then 1; all outputs 0.
- One-shot: arm ch2, cmp=100, time_i ramps from 90 -> pending_o[2]=1 within 4 cycles of time_i=100, armed_o[2]=0; irq_o=1 only if irq_en_i[2]=1.
- Periodic: ch0 cmp=50, period=20, no ack -> fires at 50, 70, 90; second fire sets overrun_o[0]=1; ack_i[0] clears both.
- Wrap: ch1 cmp=0x0000_0000_0000_0005, time_i=0xFFFF_FFFF_FFFF_FFF0 -> no fire; fires after time_i wraps past 5.
- Collision: cfg write to ch3 in the visit cycle where ch3 would fire -> no pending, new cmp loaded; separately ack_i[1] coincident with ch1 fire -> pending_o[1] remains 1.
- enable_i=0 with time past cmp -> no fire; set enable_i=1 -> fire within N_CH cycles. Reset mid-SCAN -> all flags 0, INIT re-run.
